f1_start_sequencer: RTL and testbench

//  Controller for the F1 start-lights FSM: on a start request, steps the lights FSM through
//  S1..S8 at a fixed tick rate, holds all lights lit for a pseudo-random delay, then clears

---
 rtl/f1_start_sequencer_if.sv | 25 ++
 rtl/f1_start_sequencer.sv | 133 +++++++++++++
 tb/tb_f1_start_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/f1_start_sequencer_if.sv
// Handshake bundle between the F1 start sequencer and its surroundings:
// start/button requests in, lights FSM control and reaction results out.
interface f1_start_sequencer_if #(
    parameter int REACT_W = 16
);
    logic               trigger;
    logic               button;
    logic               lights_en;
    logic               lights_rst;
    logic               lights_out;
    logic               busy;
    logic [REACT_W-1:0] react_time;
    logic               react_valid;
    logic               jump_start;

    modport slave (
        input  trigger, button,
        output lights_en, lights_rst, lights_out, busy, react_time, react_valid, jump_start
    );

    modport master (
        output trigger, button,
        input  lights_en, lights_rst, lights_out, busy, react_time, react_valid, jump_start
    );
endinterface

// File: rtl/f1_start_sequencer.sv
// F1 start-lights controller: steps the lights FSM, holds for a random delay, then times
// the driver. Define F1_SEQ_TIMEOUT_EN to abandon the reaction wait when the counter saturates.
module f1_start_sequencer #(
    parameter int TICK_DIV   = 24,
    parameter int LFSR_WIDTH = 7,
    parameter int REACT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    f1_start_sequencer_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] REACT = 2'd3;

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [1:0]            state;
    logic [TW-1:0]         tick_cnt;
    logic [2:0]            step_cnt;
    logic [LFSR_WIDTH-1:0] hold_cnt;
    logic [LFSR_WIDTH-1:0] hold_len;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic [REACT_W-1:0]    react_cnt;
    logic [REACT_W-1:0]    react_time_q;
    logic                  trigger_q;
    logic                  button_q;

    logic trig_edge;
    logic btn_edge;
    logic tick_wrap;
    logic jump;
    logic hold_done;
    logic react_sat;
    logic timeout_hit;
    logic react_done;

    assign trig_edge = bus.trigger & ~trigger_q;
    assign btn_edge  = bus.button & ~button_q;
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign jump      = btn_edge && ((state == COUNT) || (state == HOLD));
    assign hold_done = (state == HOLD) && tick_wrap && (hold_cnt == hold_len - 1'b1);
    assign react_sat = (react_cnt == {REACT_W{1'b1}});

`ifdef F1_SEQ_TIMEOUT_EN
    assign timeout_hit = react_sat;
`else
    assign timeout_hit = 1'b0;
`endif

    assign react_done = (state == REACT) && (btn_edge || timeout_hit);

    // The COUNT entry cycle is the only one with both counters at zero, so it needs no flag.
    assign bus.lights_rst  = ((state == COUNT) && (tick_cnt == '0) && (step_cnt == '0))
                             || hold_done || jump;
    assign bus.lights_en   = (state == COUNT) && tick_wrap && !jump;
    assign bus.lights_out  = (state == REACT);
    assign bus.busy        = (state != IDLE);
    assign bus.react_valid = react_done;
    assign bus.jump_start  = jump;
    assign bus.react_time  = react_time_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            step_cnt     <= '0;
            hold_cnt     <= '0;
            hold_len     <= '0;
            lfsr         <= LFSR_WIDTH'(1);
            react_cnt    <= '0;
            react_time_q <= '0;
            trigger_q    <= 1'b0;
            button_q     <= 1'b0;
        end else begin
            trigger_q <= bus.trigger;
            button_q  <= bus.button;
            // Taps at the top two bits give x^7+x^6+1 for the default width.
            lfsr      <= {lfsr[LFSR_WIDTH-2:0], lfsr[LFSR_WIDTH-1] ^ lfsr[LFSR_WIDTH-2]};

            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state    <= COUNT;
                        tick_cnt <= '0;
                        step_cnt <= '0;
                    end
                end
                COUNT: begin
                    if (jump) begin
                        state <= IDLE;
                    end else begin
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
                        if (tick_wrap) begin
                            step_cnt <= step_cnt + 1'b1;
                            if (step_cnt == 3'd7) begin
                                state    <= HOLD;
                                hold_len <= lfsr;
                                hold_cnt <= '0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (jump) begin
                        state <= IDLE;
                    end else begin
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
                        if (hold_done) begin
                            state     <= REACT;
                            react_cnt <= '0;
                        end else if (tick_wrap) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    // On timeout the counter already reads all ones, so one assignment covers both exits.
                    if (react_done) begin
                        state        <= IDLE;
                        react_time_q <= react_cnt;
                    end else if (!react_sat) begin
                        react_cnt <= react_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Randomized bench for f1_start_sequencer with TICK_DIV=4, REACT_W=8; expected timing is
// derived from cycle offsets after the trigger edge. Honours F1_SEQ_TIMEOUT_EN if defined.
module tb_f1_start_sequencer;

    localparam int NEVER = 1 << 30;
`ifdef F1_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] m_lfsr;
    logic [7:0] last_react = 8'd0;
    int         errors = 0;
    int         checks = 0;

    f1_start_sequencer_if #(.REACT_W(8)) sig ();

    f1_start_sequencer #(
        .TICK_DIV   (4),
        .LFSR_WIDTH (7),
        .REACT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sig)
    );

    always #5 clk = ~clk;

    // Reference delay generator: x^7+x^6+1, reloaded with 1 by reset.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 7'd1;
        else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    task automatic step(input logic trg, input logic btn, input logic r);
        @(negedge clk);
        sig.trigger = trg;
        sig.button  = btn;
        rst         = r;
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({sig.busy, sig.lights_en, sig.lights_rst, sig.lights_out, sig.react_valid, sig.jump_start} !== 6'b0
            || sig.react_time !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got busy/en/rst/out/valid/jump=%b time=%0d, need 000000 time=0",
                     {sig.busy, sig.lights_en, sig.lights_rst, sig.lights_out, sig.react_valid, sig.jump_start},
                     sig.react_time);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if ({sig.busy, sig.lights_rst, sig.react_valid, sig.jump_start} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL idle_button got busy/rst/valid/jump=%b, need 0000",
                     {sig.busy, sig.lights_rst, sig.react_valid, sig.jump_start});
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (sig.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_button busy=%b, need 0", sig.busy);
        end
        last_react = 8'd0;
    endtask

    // jump_mode: 0 none, 1 press in COUNT, 2 press in HOLD, 3 press on the HOLD expiry cycle.
    task automatic test_sequence(input int jump_mode, input int react_delay, input bit hold_trig,
                                 input bit rst_react);
        int         h, hold_end, r, press_k, end_k, rst_k;
        bit         done;
        logic       trg, btn, exp_en, exp_rst, exp_out, exp_valid, exp_jump;
        logic [5:0] got, exp;
        hold_end = NEVER; r = NEVER; end_k = NEVER; rst_k = NEVER; done = 1'b0;
        press_k  = (jump_mode == 1) ? int'($urandom_range(32, 1)) : NEVER;

        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (sig.busy !== 1'b0 || sig.lights_rst !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_cycle got busy=%b rst=%b, need 0 0", sig.busy, sig.lights_rst);
        end

        for (int k = 1; k <= 1200 && !done; k++) begin
            trg = hold_trig ? 1'b1 : ((k < 32) ? 1'($urandom) : 1'b0);
            btn = (k == press_k);
            step(trg, btn, (k == rst_k));
            if (k == 32) begin
                h        = int'(m_lfsr);
                hold_end = 32 + 4 * h;
                r        = hold_end + 1;
                if (jump_mode == 2)      press_k = int'($urandom_range(hold_end, 33));
                else if (jump_mode == 3) press_k = hold_end;
                else if (jump_mode == 0) begin
                    if (rst_react)                          rst_k = r + 5;
                    else if (TIMEOUT && react_delay > 255)  end_k = r + 255;
                    else begin
                        press_k = r + react_delay;
                        end_k   = press_k;
                    end
                end
            end
            exp_jump  = (k == press_k) && (k < r);
            exp_en    = (k <= 32) && (k % 4 == 0) && !exp_jump;
            exp_rst   = (k == 1) || (k == hold_end) || exp_jump;
            exp_out   = (k >= r);
            exp_valid = (k == end_k);
            got = {sig.busy, sig.lights_en, sig.lights_rst, sig.lights_out, sig.react_valid, sig.jump_start};
            exp = {1'b1, exp_en, exp_rst, exp_out, exp_valid, exp_jump};
            checks++;
            if (got !== exp || sig.react_time !== last_react) begin
                errors++;
                $display("[TB] FAIL seq_cycle k=%0d busy/en/rst/out/valid/jump got %b need %b, time got %0d need %0d",
                         k, got, exp, sig.react_time, last_react);
            end
            if (exp_jump || exp_valid || k == rst_k) begin
                if (exp_valid)  last_react = (react_delay >= 255) ? 8'hFF : 8'(react_delay);
                if (k == rst_k) last_react = 8'd0;
                step(hold_trig, 1'b0, 1'b0);
                got = {sig.busy, sig.lights_en, sig.lights_rst, sig.lights_out, sig.react_valid, sig.jump_start};
                checks++;
                if (got !== 6'b0 || sig.react_time !== last_react) begin
                    errors++;
                    $display("[TB] FAIL after_seq got busy/en/rst/out/valid/jump=%b time=%0d, need 000000 time=%0d",
                             got, sig.react_time, last_react);
                end
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL seq_timeout sequence did not finish within 1200 cycles, need finish");
        end
    endtask

    task automatic test_reaction();
        test_sequence(0, 10, 1'b0, 1'b0);
        test_sequence(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) test_sequence(0, int'($urandom_range(60, 1)), 1'b0, 1'b0);
    endtask

    task automatic test_jump_start();
        test_sequence(1, 0, 1'b0, 1'b0);
        test_sequence(2, 0, 1'b0, 1'b0);
        test_sequence(3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_trigger_hold();
        test_sequence(1, 0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (sig.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL trigger_hold cycle %0d busy=%b, need 0", i, sig.busy);
            end
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_react();
        test_sequence(0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        test_sequence(0, 300, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_sequence(0, int'($urandom_range(20, 0)), 1'b0, 1'b0);
        test_sequence(0, int'($urandom_range(20, 0)), 1'b0, 1'b0);
    endtask

    initial begin
        sig.trigger = 1'b0;
        sig.button  = 1'b0;
        test_reset();
        test_reaction();
        test_jump_start();
        test_trigger_hold();
        test_reset_in_react();
        test_timeout();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
